// File: rtl/sum_arbiter_pkg.sv
// Shared types for the sum_arbiter block: FSM state encoding and the
// requester-ID width helper.
package sum_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sum_arb_state_t;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/sum.sv
// Registered adder: the sum and carry of in1+in2 appear one cycle after
// sum_in_en, flagged by sum_out_en.
module sum #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 sum_in_en,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    output logic                 sum_out_en,
    output logic [BUS_WIDTH-1:0] sum_out,
    output logic                 carry_out
);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sum_out_en <= 1'b0;
            sum_out    <= '0;
            carry_out  <= 1'b0;
        end else begin
            sum_out_en <= sum_in_en;
            if (sum_in_en) begin
                {carry_out, sum_out} <= {1'b0, in1} + {1'b0, in2};
            end
        end
    end

endmodule

// File: rtl/sum_rr_picker.sv
// Combinational requester picker: round-robin from ptr by default, lowest
// index wins when SUM_ARBITER_FIXED_PRIO_EN is defined (ptr is then ignored).
module sum_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic found;

`ifdef SUM_ARBITER_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end
`else
    // Two passes give the wrapped search: indices at/after ptr first, then below it.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i < int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/sum_arbiter.sv
// Arbitrates NUM_REQ operand requesters onto one registered sum adder and returns
// sum/carry/id on a response channel. SUM_ARBITER_FIXED_PRIO_EN selects fixed priority.
module sum_arbiter
    import sum_arbiter_pkg::*;
#(
    parameter  int BUS_WIDTH = 32,
    parameter  int NUM_REQ   = 4,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in2,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [BUS_WIDTH-1:0]         resp_sum,
    output logic                         resp_carry,
    output logic [ID_W-1:0]              resp_id
);

    sum_arb_state_t       state, state_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id, ptr, op_id;
    logic [BUS_WIDTH-1:0] sel_a, sel_b, op_a, op_b, add_sum;
    logic                 accept, add_in_en, add_out_en, add_carry;

    sum_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    sum #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_sum (
        .clk        (clk),
        .arst       (arst),
        .sum_in_en  (add_in_en),
        .in1        (op_a),
        .in2        (op_b),
        .sum_out_en (add_out_en),
        .sum_out    (add_sum),
        .carry_out  (add_carry)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: req_ready is qualified by arst so the grant stays silent while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        add_in_en = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = arst ? grant : '0;
                if (|(req_valid & req_ready)) state_nxt = ISSUE;
            end
            ISSUE: begin
                add_in_en = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    if (add_out_en) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept     = |(req_valid & req_ready);
    assign resp_valid = (state == RESP);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_in1[i*BUS_WIDTH +: BUS_WIDTH];
                sel_b = req_in2[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // NOTE: operand registers are reset as well so the adder never sees X after reset.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            resp_sum   <= '0;
            resp_carry <= 1'b0;
            resp_id    <= '0;
        end else begin
            if (accept) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                op_id <= grant_id;
            end
            if (state == WAIT && add_out_en) begin
                resp_sum   <= add_sum;
                resp_carry <= add_carry;
                resp_id    <= op_id;
            end
        end
    end

`ifdef SUM_ARBITER_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_id + 1'b1);
        end
    end
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// Directed + randomized bench for sum_arbiter (NUM_REQ=4, BUS_WIDTH=8) against a
// behavioural model of the grant order and arithmetic.
module tb_sum_arbiter;

    localparam int NR = 4;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            arst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*BW-1:0] req_in1, req_in2;
    logic            resp_valid, resp_ready;
    logic [BW-1:0]   resp_sum;
    logic            resp_carry;
    logic [1:0]      resp_id;

    int checks = 0;
    int errors = 0;

    int        rr_ptr = 0;
    logic [7:0] a_arr [NR];
    logic [7:0] b_arr [NR];

    sum_arbiter #(
        .BUS_WIDTH (BW),
        .NUM_REQ   (NR)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: scan from the model pointer, wrapping modulo NR.
    function automatic int pick(input logic [NR-1:0] v);
`ifdef SUM_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (rr_ptr + k) % NR;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            req_in1[i*BW +: BW] = a_arr[i];
            req_in2[i*BW +: BW] = b_arr[i];
        end
    endtask

    task automatic check_resp(input string tag, input int w);
        int full;
        full = int'(a_arr[w]) + int'(b_arr[w]);
        check({tag, ".resp_valid"}, resp_valid, 1);
        check({tag, ".resp_sum"},   resp_sum,   full % 256);
        check({tag, ".resp_carry"}, resp_carry, full / 256);
        check({tag, ".resp_id"},    resp_id,    w);
        check({tag, ".ready_resp"}, req_ready,  0);
    endtask

    // One full operation: grant at T, busy T+1..T+2, response T+3, then `stall` extra cycles.
    task automatic run_op(input logic [NR-1:0] v, input int stall, input string tag);
        int w;
        @(negedge clk);
        req_valid  = v;
        drive_ops();
        resp_ready = (stall == 0);
        #1;
        w = pick(v);
        if (w < 0) begin
            check({tag, ".no_grant"}, req_ready, 0);
            return;
        end
        check({tag, ".grant"}, req_ready, 32'd1 << w);
`ifndef SUM_ARBITER_FIXED_PRIO_EN
        rr_ptr = (w + 1) % NR;
`endif
        repeat (2) begin
            @(negedge clk); #1;
            check({tag, ".busy_ready"}, req_ready, 0);
            check({tag, ".busy_valid"}, resp_valid, 0);
        end
        @(negedge clk); #1;
        check_resp(tag, w);
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            if (s == stall) resp_ready = 1'b1;
            #1;
            check_resp({tag, ".held"}, w);
        end
    endtask

    initial begin
        int w;
        arst       = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = 8'h00;
            b_arr[i] = 8'h00;
        end
        drive_ops();
        #2;
        check("rst.req_ready",  req_ready,  0);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.resp_sum",   resp_sum,   0);
        check("rst.resp_carry", resp_carry, 0);
        check("rst.resp_id",    resp_id,    0);

        @(negedge clk);
        arst = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            check("idle.req_ready",  req_ready,  0);
            check("idle.resp_valid", resp_valid, 0);
        end

        // All requesters busy: five back-to-back operations.
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = 8'($urandom);
            b_arr[i] = 8'($urandom);
        end
        for (int n = 0; n < 5; n++) run_op(4'hF, 0, "all_busy");

        // Single request with carry out and zero sum.
        a_arr[1] = 8'hFF;
        b_arr[1] = 8'h01;
        run_op(4'b0010, 0, "single");

        // Pointer wrap: grant to 3, then 0 and 2 compete.
        run_op(4'b1000, 0, "wrap3");
        run_op(4'b0101, 0, "wrap_a");
        run_op(4'b0101, 0, "wrap_b");

        // Backpressure for five cycles.
        a_arr[2] = 8'h12;
        b_arr[2] = 8'h34;
        run_op(4'b0100, 5, "bp");

        // Reset while the operation sits in WAIT.
        @(negedge clk);
        req_valid  = 4'b0010;
        resp_ready = 1'b1;
        drive_ops();
        #1;
        w = pick(4'b0010);
        check("rstop.grant", req_ready, 32'd1 << w);
        @(negedge clk);
        req_valid = 4'hF;
        @(negedge clk);
        arst = 1'b0;
        #1;
        rr_ptr = 0;
        check("rstop.req_ready",  req_ready,  0);
        check("rstop.resp_valid", resp_valid, 0);
        check("rstop.resp_sum",   resp_sum,   0);
        check("rstop.resp_carry", resp_carry, 0);
        check("rstop.resp_id",    resp_id,    0);
        @(negedge clk);
        req_valid = '0;
        arst      = 1'b1;
        #1;
        check("rstop.released_valid", resp_valid, 0);
        repeat (3) begin
            @(negedge clk); #1;
            check("rstop.no_resp", resp_valid, 0);
        end
        run_op(4'hF, 0, "post_rst");

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NR; i++) begin
                a_arr[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                b_arr[i] = 8'($urandom);
            end
            run_op(4'($urandom_range(1, 15)), $urandom_range(0, 2), "rand");
        end

        @(negedge clk);
        req_valid = '0;
        #1;
        check("end.idle_ready", req_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
